// File: rtl/shell_judge_if.sv
// Bundle of every signal exchanged between the game judge and its neighbours
// (key inputs, shell array, map ROM, tank positions and the scoreboard outputs).
// The judge connects through the slave modport; whatever drives the judge's
// inputs and consumes its results uses the master modport.
interface shell_judge_if;
  // Round control and raw fire keys
  logic        game_restart;
  logic        fire_btn_1;
  logic        fire_btn_2;

  // Shell array state: per-slot idle flag and packed {slot4..slot0} coordinates
  logic [4:0]  valid_1_shell;
  logic [4:0]  valid_2_shell;
  logic [29:0] shell_1_x_pos;
  logic [29:0] shell_1_y_pos;
  logic [29:0] shell_2_x_pos;
  logic [29:0] shell_2_y_pos;

  // Tank cells
  logic [5:0]  tank_1_x_pos;
  logic [5:0]  tank_1_y_pos;
  logic [5:0]  tank_2_x_pos;
  logic [5:0]  tank_2_y_pos;

  // Map ROM port
  logic        map_wall;
  logic [5:0]  map_rd_x;
  logic [5:0]  map_rd_y;

  // Fire gating towards the shell array
  logic        fire_1;
  logic        fire_2;
  logic        valid_give_shell_1;
  logic        valid_give_shell_2;

  // Collision results and scoreboard
  logic [4:0]  vanish_1;
  logic [4:0]  vanish_2;
  logic        hit_1;
  logic        hit_2;
  logic [1:0]  lives_1;
  logic [1:0]  lives_2;
  logic        game_over;
  logic [1:0]  winner;

  modport slave (
    input  game_restart, fire_btn_1, fire_btn_2,
    input  valid_1_shell, valid_2_shell,
    input  shell_1_x_pos, shell_1_y_pos, shell_2_x_pos, shell_2_y_pos,
    input  tank_1_x_pos, tank_1_y_pos, tank_2_x_pos, tank_2_y_pos,
    input  map_wall,
    output map_rd_x, map_rd_y,
    output fire_1, fire_2, valid_give_shell_1, valid_give_shell_2,
    output vanish_1, vanish_2, hit_1, hit_2,
    output lives_1, lives_2, game_over, winner
  );

  modport master (
    output game_restart, fire_btn_1, fire_btn_2,
    output valid_1_shell, valid_2_shell,
    output shell_1_x_pos, shell_1_y_pos, shell_2_x_pos, shell_2_y_pos,
    output tank_1_x_pos, tank_1_y_pos, tank_2_x_pos, tank_2_y_pos,
    output map_wall,
    input  map_rd_x, map_rd_y,
    input  fire_1, fire_2, valid_give_shell_1, valid_give_shell_2,
    input  vanish_1, vanish_2, hit_1, hit_2,
    input  lives_1, lives_2, game_over, winner
  );
endinterface

// File: rtl/shell_judge.sv
// Game judge for the two-tank shooter. Gates fire requests with a per-player
// cooldown, scans the ten shell slots round-robin (two cycles per slot) against
// bounds, map walls and the opposing tank, pulses per-slot vanish and per-tank
// hit, and keeps lives, game-over and the winner.
module shell_judge #(
  parameter int X_MAX    = 39,
  parameter int Y_MAX    = 29,
  parameter int COOLDOWN = 2_000_000,
  parameter int LIVES    = 3
) (
  input logic          clk,
  input logic          rst,
  shell_judge_if.slave bus
);

  localparam int              CD_W       = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);
  localparam logic [CD_W-1:0] CD_LOAD    = CD_W'(COOLDOWN);
  localparam logic [1:0]      LIVES_INIT = 2'(LIVES);
  localparam logic [3:0]      LAST_SLOT  = 4'd9;
  localparam logic [3:0]      T2_BASE    = 4'd5;
  localparam logic [5:0]      X_LIM      = 6'(X_MAX);
  localparam logic [5:0]      Y_LIM      = 6'(Y_MAX);

  // Lives never go below zero, however many hits land in one scan.
  function automatic logic [1:0] f_lives_dec(input logic [1:0] lives, input logic hit);
    return (hit && (lives != 2'd0)) ? lives - 2'd1 : lives;
  endfunction

  // A grant reloads the cooldown; otherwise it counts down and rests at zero.
  function automatic logic [CD_W-1:0] f_cd_next(input logic [CD_W-1:0] cd, input logic grant);
    if (grant) return CD_LOAD;
    return (cd != '0) ? cd - CD_W'(1) : cd;
  endfunction

  typedef enum logic {S_REQ, S_CHK} state_t;

  state_t          r_state, w_state_nxt;
  logic [3:0]      r_slot, w_slot_nxt;
  logic            w_req, w_chk;

  logic            w_slot_t2;
  logic [2:0]      w_sub;
  logic [5:0]      w_sel_x, w_sel_y;
  logic            w_sel_idle;

  logic [5:0]      r_cap_x, r_cap_y;
  logic            r_cap_idle;
  logic [5:0]      r_map_x, r_map_y;

  logic [5:0]      w_opp_x, w_opp_y;
  logic            w_active, w_oob, w_on_tank, w_vanish_now, w_hit_now;
  logic [4:0]      w_van_1, w_van_2;
  logic            w_hit_1, w_hit_2;
  logic [1:0]      w_lives_1_nxt, w_lives_2_nxt;
  logic            w_end_scan, w_go_set, w_go_nxt;
  logic [1:0]      w_winner_nxt;

  logic [4:0]      r_vanish_1, r_vanish_2;
  logic            r_hit_1, r_hit_2;
  logic [1:0]      r_lives_1, r_lives_2;
  logic            r_go;
  logic [1:0]      r_winner;

  logic [1:0]      w_btn, r_btn_d, w_edge, w_grant, w_vg_nxt;
  logic [1:0]      r_fire, r_vg;
  logic [CD_W-1:0] r_cd_1, r_cd_2, w_cd_1_nxt, w_cd_2_nxt;

  // ---------------------------------------------------------------------------
  // Scan sequencer: REQ captures a slot and addresses the ROM, CHK judges it
  // ---------------------------------------------------------------------------

  // State and slot registers; a restart rewinds the scan to slot 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_REQ;
      r_slot  <= '0;
    end else if (bus.game_restart) begin
      r_state <= S_REQ;
      r_slot  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_slot  <= w_slot_nxt;
    end
  end

  // Next state: alternate REQ/CHK, advance the slot after each CHK, wrap 9 -> 0
  always_comb begin
    w_state_nxt = r_state;
    w_slot_nxt  = r_slot;
    w_req       = 1'b0;
    w_chk       = 1'b0;
    unique case (r_state)
      S_REQ: begin
        w_req       = 1'b1;
        w_state_nxt = S_CHK;
      end
      S_CHK: begin
        w_chk       = 1'b1;
        w_state_nxt = S_REQ;
        w_slot_nxt  = (r_slot == LAST_SLOT) ? 4'd0 : r_slot + 4'd1;
      end
    endcase
  end

  // Slot mux: slots 0..4 belong to tank 1, 5..9 to tank 2
  always_comb begin
    w_slot_t2  = (r_slot >= T2_BASE);
    w_sub      = 3'(w_slot_t2 ? (r_slot - T2_BASE) : r_slot);
    w_sel_x    = w_slot_t2 ? bus.shell_2_x_pos[int'(w_sub)*6 +: 6]
                           : bus.shell_1_x_pos[int'(w_sub)*6 +: 6];
    w_sel_y    = w_slot_t2 ? bus.shell_2_y_pos[int'(w_sub)*6 +: 6]
                           : bus.shell_1_y_pos[int'(w_sub)*6 +: 6];
    w_sel_idle = w_slot_t2 ? bus.valid_2_shell[w_sub] : bus.valid_1_shell[w_sub];
  end

  // ---------------------------------------------------------------------------
  // REQ -> CHK boundary: slot snapshot and ROM address
  // ---------------------------------------------------------------------------

  // Slot snapshot; only ever read in the CHK that follows its REQ, so no reset
  always_ff @(posedge clk) begin
    if (w_req) begin
      r_cap_x    <= w_sel_x;
      r_cap_y    <= w_sel_y;
      r_cap_idle <= w_sel_idle;
    end
  end

  // Map ROM address, loaded in REQ so the wall bit is present during CHK
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_map_x <= '0;
      r_map_y <= '0;
    end else if (bus.game_restart) begin
      r_map_x <= '0;
      r_map_y <= '0;
    end else if (w_req) begin
      r_map_x <= w_sel_x;
      r_map_y <= w_sel_y;
    end
  end

  // Judgement of the captured slot plus the scoreboard updates it implies
  always_comb begin
    w_opp_x       = w_slot_t2 ? bus.tank_1_x_pos : bus.tank_2_x_pos;
    w_opp_y       = w_slot_t2 ? bus.tank_1_y_pos : bus.tank_2_y_pos;
    w_active      = w_chk && !r_cap_idle;
    // Coordinates are unsigned, so a shell that stepped below 0 shows up as 63
    w_oob         = (r_cap_x > X_LIM) || (r_cap_y > Y_LIM);
    w_on_tank     = (r_cap_x == w_opp_x) && (r_cap_y == w_opp_y);
    // An out-of-bounds address reads junk from the ROM, but the slot vanishes anyway
    w_vanish_now  = w_active && (w_oob || bus.map_wall || w_on_tank);
    w_hit_now     = w_active && !w_oob && w_on_tank && !r_go;
    w_van_1       = (w_vanish_now && !w_slot_t2) ? (5'b00001 << w_sub) : 5'b00000;
    w_van_2       = (w_vanish_now &&  w_slot_t2) ? (5'b00001 << w_sub) : 5'b00000;
    // A tank-2 shell hits tank 1 and vice versa
    w_hit_1       = w_hit_now &&  w_slot_t2;
    w_hit_2       = w_hit_now && !w_slot_t2;
    w_lives_1_nxt = f_lives_dec(r_lives_1, w_hit_1);
    w_lives_2_nxt = f_lives_dec(r_lives_2, w_hit_2);
    // The round is decided only once a full scan has been judged
    w_end_scan    = w_chk && (r_slot == LAST_SLOT);
    w_go_set      = !r_go && w_end_scan &&
                    ((w_lives_1_nxt == 2'd0) || (w_lives_2_nxt == 2'd0));
    w_go_nxt      = r_go || w_go_set;
    w_winner_nxt  = w_go_set ? {w_lives_1_nxt == 2'd0, w_lives_2_nxt == 2'd0} : r_winner;
  end

  // ---------------------------------------------------------------------------
  // CHK -> output boundary: vanish/hit pulses and scoreboard
  // ---------------------------------------------------------------------------

  // Registered judgement results; restart overrides anything judged this cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vanish_1 <= '0;
      r_vanish_2 <= '0;
      r_hit_1    <= 1'b0;
      r_hit_2    <= 1'b0;
      r_lives_1  <= LIVES_INIT;
      r_lives_2  <= LIVES_INIT;
      r_go       <= 1'b0;
      r_winner   <= 2'b00;
    end else if (bus.game_restart) begin
      r_vanish_1 <= '0;
      r_vanish_2 <= '0;
      r_hit_1    <= 1'b0;
      r_hit_2    <= 1'b0;
      r_lives_1  <= LIVES_INIT;
      r_lives_2  <= LIVES_INIT;
      r_go       <= 1'b0;
      r_winner   <= 2'b00;
    end else begin
      r_vanish_1 <= w_van_1;
      r_vanish_2 <= w_van_2;
      r_hit_1    <= w_hit_1;
      r_hit_2    <= w_hit_2;
      r_lives_1  <= w_lives_1_nxt;
      r_lives_2  <= w_lives_2_nxt;
      r_go       <= w_go_nxt;
      r_winner   <= w_winner_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Fire gating: rising edge of a key fires once, then the cooldown blocks it
  // ---------------------------------------------------------------------------

  assign w_btn = {bus.fire_btn_2, bus.fire_btn_1};

  // Previous key level for edge detection; it tracks the keys through restarts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_btn_d <= 2'b00;
    else     r_btn_d <= w_btn;
  end

  // Edge/grant decode; the permit is computed from next-cycle state so it drops
  // in the same cycle as the fire pulse and a fresh edge cannot double-fire
  always_comb begin
    w_edge      = w_btn & ~r_btn_d;
    w_grant     = w_edge & r_vg;
    w_cd_1_nxt  = f_cd_next(r_cd_1, w_grant[0]);
    w_cd_2_nxt  = f_cd_next(r_cd_2, w_grant[1]);
    w_vg_nxt[0] = (w_cd_1_nxt == '0) && !w_go_nxt;
    w_vg_nxt[1] = (w_cd_2_nxt == '0) && !w_go_nxt;
  end

  // Fire pulse, cooldown counters and fire permit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fire <= 2'b00;
      r_vg   <= 2'b00;
      r_cd_1 <= '0;
      r_cd_2 <= '0;
    end else if (bus.game_restart) begin
      r_fire <= 2'b00;
      r_vg   <= 2'b00;
      r_cd_1 <= '0;
      r_cd_2 <= '0;
    end else begin
      r_fire <= w_grant;
      r_vg   <= w_vg_nxt;
      r_cd_1 <= w_cd_1_nxt;
      r_cd_2 <= w_cd_2_nxt;
    end
  end

  assign bus.map_rd_x           = r_map_x;
  assign bus.map_rd_y           = r_map_y;
  assign bus.fire_1             = r_fire[0];
  assign bus.fire_2             = r_fire[1];
  assign bus.valid_give_shell_1 = r_vg[0];
  assign bus.valid_give_shell_2 = r_vg[1];
  assign bus.vanish_1           = r_vanish_1;
  assign bus.vanish_2           = r_vanish_2;
  assign bus.hit_1              = r_hit_1;
  assign bus.hit_2              = r_hit_2;
  assign bus.lives_1            = r_lives_1;
  assign bus.lives_2            = r_lives_2;
  assign bus.game_over          = r_go;
  assign bus.winner             = r_winner;

endmodule

// File: tb/tb_shell_judge.sv
// Bench for shell_judge: directed round scenarios followed by randomized rounds,
// every cycle compared against a rule-level model of the game.
module tb_shell_judge;
  localparam int CD = 8;

  logic clk = 1'b0;
  logic rst;

  shell_judge_if bus ();

  shell_judge #(.X_MAX(39), .Y_MAX(29), .COOLDOWN(CD), .LIVES(3)) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Map ROM: one hand-placed wall plus a diagonal pattern
  function automatic logic wall_at(input logic [5:0] x, input logic [5:0] y);
    return ((x == 6'd5) && (y == 6'd7)) || (((int'(x) + 2 * int'(y)) % 13) == 4);
  endfunction

  assign bus.map_wall = wall_at(bus.map_rd_x, bus.map_rd_y);

  // Scene held for a whole scan: slots 0..4 tank 1, 5..9 tank 2
  logic [5:0] c_x [10];
  logic [5:0] c_y [10];
  logic       c_idle [10];
  logic [5:0] c_t1x, c_t1y, c_t2x, c_t2y;

  // Reference game state
  int         m_n;        // scan edge index since reset/restart
  int         m_e;        // absolute edge index since reset release
  int         m_allow [2];
  logic [1:0] m_prev;
  int         m_l1, m_l2;
  logic       m_go;
  logic [1:0] m_win;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic drive_cfg();
    for (int k = 0; k < 5; k++) begin
      bus.shell_1_x_pos[k*6 +: 6] = c_x[k];
      bus.shell_1_y_pos[k*6 +: 6] = c_y[k];
      bus.valid_1_shell[k]        = c_idle[k];
      bus.shell_2_x_pos[k*6 +: 6] = c_x[k+5];
      bus.shell_2_y_pos[k*6 +: 6] = c_y[k+5];
      bus.valid_2_shell[k]        = c_idle[k+5];
    end
    bus.tank_1_x_pos = c_t1x;
    bus.tank_1_y_pos = c_t1y;
    bus.tank_2_x_pos = c_t2x;
    bus.tank_2_y_pos = c_t2y;
  endtask

  task automatic clear_cfg();
    for (int k = 0; k < 10; k++) begin
      c_x[k]    = 6'd0;
      c_y[k]    = 6'd0;
      c_idle[k] = 1'b1;
    end
    c_t1x = 6'd20; c_t1y = 6'd20;
    c_t2x = 6'd10; c_t2y = 6'd10;
  endtask

  task automatic rand_cfg();
    int r;
    c_t1x = 6'($urandom_range(0, 39)); c_t1y = 6'($urandom_range(0, 29));
    c_t2x = 6'($urandom_range(0, 39)); c_t2y = 6'($urandom_range(0, 29));
    for (int k = 0; k < 10; k++) begin
      c_idle[k] = ($urandom_range(0, 2) == 0);
      r = $urandom_range(0, 9);
      case (r)
        0, 1: begin c_x[k] = (k < 5) ? c_t2x : c_t1x; c_y[k] = (k < 5) ? c_t2y : c_t1y; end
        2:    begin c_x[k] = 6'($urandom_range(40, 63)); c_y[k] = 6'($urandom_range(0, 29)); end
        3:    begin c_x[k] = 6'($urandom_range(0, 39)); c_y[k] = 6'($urandom_range(30, 63)); end
        4:    begin c_x[k] = 6'd5; c_y[k] = 6'd7; end
        default: begin c_x[k] = 6'($urandom_range(0, 39)); c_y[k] = 6'($urandom_range(0, 29)); end
      endcase
    end
  endtask

  // One clock: drive inputs, predict from the game rules, then compare
  task automatic step(input logic rs, input logic b1, input logic b2);
    logic [1:0] btn, e_fire, e_vg;
    logic [4:0] e_v1, e_v2;
    logic       e_h1, e_h2, gob, map_chk, oob, on;
    logic [5:0] e_mx, e_my, x, y, ox, oy;
    int         k;
    btn = {b2, b1};
    bus.game_restart = rs;
    bus.fire_btn_1   = b1;
    bus.fire_btn_2   = b2;
    e_fire = 2'b00; e_v1 = 5'd0; e_v2 = 5'd0; e_h1 = 1'b0; e_h2 = 1'b0;
    map_chk = 1'b0; e_mx = 6'd0; e_my = 6'd0;
    if (rs) begin
      m_l1 = 3; m_l2 = 3; m_go = 1'b0; m_win = 2'b00; m_n = 0;
      m_allow[0] = m_e + 2; m_allow[1] = m_e + 2;
    end else begin
      gob = m_go;
      for (int p = 0; p < 2; p++) begin
        if (btn[p] && !m_prev[p] && (m_e >= m_allow[p]) && !gob) begin
          e_fire[p]  = 1'b1;
          m_allow[p] = m_e + CD + 1;
        end
      end
      k = (m_n / 2) % 10;
      if ((m_n % 2) == 0) begin
        map_chk = 1'b1; e_mx = c_x[k]; e_my = c_y[k];
      end else if (!c_idle[k]) begin
        x   = c_x[k]; y = c_y[k];
        ox  = (k < 5) ? c_t2x : c_t1x;
        oy  = (k < 5) ? c_t2y : c_t1y;
        oob = (x > 6'd39) || (y > 6'd29);
        on  = (x == ox) && (y == oy);
        if (oob || on || wall_at(x, y)) begin
          if (k < 5) e_v1[k] = 1'b1;
          else       e_v2[k-5] = 1'b1;
        end
        if (on && !oob && !m_go) begin
          if (k < 5) begin e_h2 = 1'b1; if (m_l2 > 0) m_l2--; end
          else       begin e_h1 = 1'b1; if (m_l1 > 0) m_l1--; end
        end
      end
      if (((m_n % 2) == 1) && (k == 9) && !m_go && ((m_l1 == 0) || (m_l2 == 0))) begin
        m_go  = 1'b1;
        m_win = {m_l1 == 0, m_l2 == 0};
      end
      m_n++;
    end
    m_prev = btn;
    for (int p = 0; p < 2; p++) e_vg[p] = ((m_e + 1) >= m_allow[p]) && !m_go;
    m_e++;
    @(posedge clk);
    #1;
    chk("fire_1",   32'(bus.fire_1), 32'(e_fire[0]));
    chk("fire_2",   32'(bus.fire_2), 32'(e_fire[1]));
    chk("vgive_1",  32'(bus.valid_give_shell_1), 32'(e_vg[0]));
    chk("vgive_2",  32'(bus.valid_give_shell_2), 32'(e_vg[1]));
    chk("vanish_1", 32'(bus.vanish_1), 32'(e_v1));
    chk("vanish_2", 32'(bus.vanish_2), 32'(e_v2));
    chk("hit_1",    32'(bus.hit_1), 32'(e_h1));
    chk("hit_2",    32'(bus.hit_2), 32'(e_h2));
    chk("lives_1",  32'(bus.lives_1), 32'(m_l1));
    chk("lives_2",  32'(bus.lives_2), 32'(m_l2));
    chk("game_over", 32'(bus.game_over), 32'(m_go));
    chk("winner",   32'(bus.winner), 32'(m_win));
    if (map_chk) begin
      chk("map_rd_x", 32'(bus.map_rd_x), 32'(e_mx));
      chk("map_rd_y", 32'(bus.map_rd_y), 32'(e_my));
    end
  endtask

  initial begin
    int cnt, cnt_low, seen;
    rst = 1'b1;
    bus.game_restart = 1'b0;
    bus.fire_btn_1 = 1'b0;
    bus.fire_btn_2 = 1'b0;
    clear_cfg();
    drive_cfg();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    m_n = 0; m_e = 0; m_allow[0] = 1; m_allow[1] = 1; m_prev = 2'b00;
    m_l1 = 3; m_l2 = 3; m_go = 1'b0; m_win = 2'b00;

    // Post-reset state before the first edge
    chk("rst_fire",   32'({bus.fire_1, bus.fire_2}), 32'd0);
    chk("rst_vanish", 32'({bus.vanish_1, bus.vanish_2}), 32'd0);
    chk("rst_hit",    32'({bus.hit_1, bus.hit_2}), 32'd0);
    chk("rst_lives",  32'({bus.lives_1, bus.lives_2}), 32'hF);
    chk("rst_go_win", 32'({bus.game_over, bus.winner}), 32'd0);
    chk("rst_vgive",  32'({bus.valid_give_shell_1, bus.valid_give_shell_2}), 32'd0);
    chk("rst_map",    32'({bus.map_rd_x, bus.map_rd_y}), 32'd0);

    // Permit appears one cycle after release
    step(1'b0, 1'b0, 1'b0);
    chk("vgive_rise", 32'(bus.valid_give_shell_1), 32'd1);

    // Held key fires once; permit low for the cooldown
    cnt = 0; cnt_low = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 1'b0);
      cnt += int'(bus.fire_1);
      cnt_low += int'(!bus.valid_give_shell_1);
    end
    chk("hold_fires", 32'(cnt), 32'd1);
    chk("cd_low_cyc", 32'(cnt_low), 32'(CD));
    step(1'b0, 1'b0, 1'b0);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, (i == 0) || (i == 2) || (i == 3), 1'b0);
      cnt += int'(bus.fire_1);
    end
    chk("cd_drop", 32'(cnt), 32'd1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // Shell wrapped to x = 63 vanishes at scan cycle 6 without a hit
    step(1'b1, 1'b0, 1'b0);
    clear_cfg();
    c_idle[2] = 1'b0; c_x[2] = 6'd63; c_y[2] = 6'd3;
    drive_cfg();
    cnt = 0; seen = -1;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, 1'b0);
      if (bus.vanish_1[2]) begin
        cnt++;
        if (seen < 0) seen = i + 1;
      end
    end
    chk("oob_cycle", 32'(seen), 32'd6);
    chk("oob_count", 32'(cnt), 32'd1);
    chk("oob_lives", 32'({bus.lives_1, bus.lives_2}), 32'hF);

    // Wall hit when flying, ignored when idle
    step(1'b1, 1'b0, 1'b0);
    clear_cfg();
    c_idle[5] = 1'b0; c_x[5] = 6'd5; c_y[5] = 6'd7;
    drive_cfg();
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, 1'b0);
      cnt += int'(bus.vanish_2[0]);
    end
    chk("wall_vanish", 32'(cnt), 32'd1);
    c_idle[5] = 1'b1;
    drive_cfg();
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, 1'b0);
      cnt += int'(bus.vanish_2[0]);
    end
    chk("idle_no_vanish", 32'(cnt), 32'd0);

    // Three scans hitting tank 2 end the round for tank 1
    step(1'b1, 1'b0, 1'b0);
    clear_cfg();
    c_idle[4] = 1'b0; c_x[4] = 6'd10; c_y[4] = 6'd10;
    drive_cfg();
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, 1'b0);
      cnt += int'(bus.hit_2);
    end
    chk("hit_count", 32'(cnt), 32'd1);
    chk("hit_lives_2", 32'(bus.lives_2), 32'd2);
    for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 1'b0);
    chk("go_set", 32'(bus.game_over), 32'd1);
    chk("go_winner", 32'(bus.winner), 32'd1);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0, 1'(i % 2));
      cnt += int'(bus.fire_2);
    end
    chk("go_no_fire", 32'(cnt), 32'd0);

    // Mutual hits down to zero in one scan give a draw; restart clears it
    step(1'b1, 1'b0, 1'b0);
    clear_cfg();
    c_idle[4] = 1'b0; c_x[4] = 6'd10; c_y[4] = 6'd10;
    c_idle[7] = 1'b0; c_x[7] = 6'd20; c_y[7] = 6'd20;
    drive_cfg();
    for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 1'b0);
    chk("mutual_lives", 32'({bus.lives_1, bus.lives_2}), 32'h5);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0);
    chk("draw_winner", 32'(bus.winner), 32'd3);
    step(1'b1, 1'b0, 1'b0);
    chk("restart_lives", 32'({bus.lives_1, bus.lives_2}), 32'hF);
    chk("restart_go", 32'(bus.game_over), 32'd0);

    // Randomized rounds with occasional restarts at scan boundaries
    for (int s = 0; s < 80; s++) begin
      if ((s == 0) || ($urandom_range(0, 3) == 0))
        step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      rand_cfg();
      drive_cfg();
      for (int i = 0; i < 20; i++)
        step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
